ldvio_vld_writer: RTL and testbench

Write-side controller for the load-violation valid RAM. Accepts load-violation training reports from the LSU through a valid/ready handshake and buffers them in a small FIFO. Drains them one per cycle onto the RAM's single write port (addr0wr/data0wr/we0). Optionally runs a periodic sweep that zeroes every RAM entry, so stale violation state decays. It sits between the LSU violation-detect logic and the RAM that dispatch reads.

---
 rtl/ldvio_vld_writer.sv | 151 +++++++++++++++
 tb/tb_ldvio_vld_writer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ldvio_vld_writer.sv
// Load-violation valid-RAM write controller: queues LSU reports and drains one per cycle to the RAM write port.
// Latency: accepted report reaches we0_o two edges later. Backpressure: viol_ready_o drops only when the report FIFO is full.
// Define LDVIO_PERIODIC_CLEAR_EN to add the periodic sweep that zeroes all DEPTH entries every CLEAR_PERIOD RUN cycles.
module ldvio_vld_writer #(
    parameter int DEPTH        = 16,
    parameter int INDEX        = 4,
    parameter int WIDTH        = 8,
    parameter int QDEPTH       = 4,
    parameter int CLEAR_PERIOD = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       viol_valid_i,
    output logic                       viol_ready_o,
    input  logic [INDEX-1:0]           viol_addr_i,
    input  logic [WIDTH-1:0]           viol_data_i,
    output logic [INDEX-1:0]           addr0wr_o,
    output logic [WIDTH-1:0]           data0wr_o,
    output logic                       we0_o,
    output logic                       sweep_busy_o,
    output logic [$clog2(QDEPTH):0]    qcount_o
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic [INDEX-1:0] q_addr [QDEPTH];
    logic [WIDTH-1:0] q_data [QDEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;
    logic             sweep_wr;
    logic [INDEX-1:0] sweep_addr;

    // Ready depends on the registered count only: a full FIFO never accepts, even while draining.
    assign viol_ready_o = (count < CW'(QDEPTH));
    assign push         = viol_valid_i && viol_ready_o;
    assign qcount_o     = count;

`ifdef LDVIO_PERIODIC_CLEAR_EN
    localparam int PCW = $clog2(CLEAR_PERIOD);

    typedef enum logic {RUN, SWEEP} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PCW-1:0]   period;
    logic [INDEX-1:0] sweep_idx;
    logic             busy;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        sweep_wr  = 1'b0;
        case (state)
            RUN: begin
                if (period == PCW'(CLEAR_PERIOD - 1)) begin
                    state_nxt = SWEEP;
                end else begin
                    pop = (count != '0);
                end
            end
            SWEEP: begin
                sweep_wr = 1'b1;
                if (sweep_idx == INDEX'(DEPTH - 1)) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            period    <= '0;
            sweep_idx <= '0;
            busy      <= 1'b0;
        end else begin
            state <= state_nxt;
            // Busy covers the entry cycle through the cycle the final sweep write is visible.
            busy  <= (state_nxt == SWEEP) || (state == SWEEP);
            if (state == RUN) begin
                if (state_nxt == SWEEP) begin
                    sweep_idx <= '0;
                end else begin
                    period <= period + 1'b1;
                end
            end else begin
                sweep_idx <= sweep_idx + 1'b1;
                if (state_nxt == RUN) begin
                    period <= '0;
                end
            end
        end
    end

    assign sweep_addr   = sweep_idx;
    assign sweep_busy_o = busy;
`else
    assign pop          = (count != '0);
    assign sweep_wr     = 1'b0;
    assign sweep_addr   = '0;
    assign sweep_busy_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[tail] <= viol_addr_i;
            q_data[tail] <= viol_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sweep and drain are mutually exclusive by state; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            we0_o     <= 1'b0;
            addr0wr_o <= '0;
            data0wr_o <= '0;
        end else if (sweep_wr) begin
            we0_o     <= 1'b1;
            addr0wr_o <= sweep_addr;
            data0wr_o <= '0;
        end else if (pop) begin
            we0_o     <= 1'b1;
            addr0wr_o <= q_addr[head];
            data0wr_o <= q_data[head];
        end else begin
            we0_o     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ldvio_vld_writer.sv
// Randomized bench for ldvio_vld_writer against a queue-based reference model; follows LDVIO_PERIODIC_CLEAR_EN.
module tb_ldvio_vld_writer;

    localparam int DEPTH  = 16;
    localparam int INDEX  = 4;
    localparam int WIDTH  = 8;
    localparam int QDEPTH = 4;
    localparam int CP     = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             viol_valid = 1'b0;
    logic             viol_ready;
    logic [INDEX-1:0] viol_addr = '0;
    logic [WIDTH-1:0] viol_data = '0;
    logic [INDEX-1:0] addr0wr;
    logic [WIDTH-1:0] data0wr;
    logic             we0;
    logic             sweep_busy;
    logic [2:0]       qcount;

    ldvio_vld_writer #(
        .DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH), .QDEPTH(QDEPTH), .CLEAR_PERIOD(CP)
    ) dut (
        .clk(clk), .reset(reset),
        .viol_valid_i(viol_valid), .viol_ready_o(viol_ready),
        .viol_addr_i(viol_addr), .viol_data_i(viol_data),
        .addr0wr_o(addr0wr), .data0wr_o(data0wr), .we0_o(we0),
        .sweep_busy_o(sweep_busy), .qcount_o(qcount)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [INDEX-1:0] a;
        logic [WIDTH-1:0] d;
    } rpt_t;

    rpt_t             mq[$];
    logic             m_we;
    logic [INDEX-1:0] m_addr;
    logic [WIDTH-1:0] m_data;
    logic             m_busy;
    int               m_period;
    int               m_pos;
    bit               m_sweeping;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_pop();
        rpt_t r;
        if (mq.size() > 0) begin
            r      = mq.pop_front();
            m_we   = 1'b1;
            m_addr = r.a;
            m_data = r.d;
        end
    endtask

    task automatic model_edge(input bit rst, input bit v, input logic [INDEX-1:0] a,
                              input logic [WIDTH-1:0] d);
        bit acc;
        rpt_t r;
        if (rst) begin
            mq.delete();
            m_we = 0; m_addr = '0; m_data = '0; m_busy = 0;
            m_period = 0; m_pos = 0; m_sweeping = 0;
            return;
        end
        acc    = v && (mq.size() < QDEPTH);
        m_we   = 1'b0;
        m_busy = 1'b0;
`ifdef LDVIO_PERIODIC_CLEAR_EN
        if (m_sweeping) begin
            m_we   = 1'b1;
            m_addr = m_pos[INDEX-1:0];
            m_data = '0;
            m_busy = 1'b1;
            m_pos++;
            if (m_pos == DEPTH) begin
                m_sweeping = 0;
                m_period   = 0;
            end
        end else if (m_period == CP - 1) begin
            m_sweeping = 1;
            m_pos      = 0;
            m_busy     = 1'b1;
        end else begin
            m_period++;
            model_pop();
        end
`else
        model_pop();
`endif
        if (acc) begin
            r.a = a;
            r.d = d;
            mq.push_back(r);
        end
    endtask

    task automatic check_outputs();
        chk("we0",    we0,        m_we);
        chk("addr",   addr0wr,    m_addr);
        chk("data",   data0wr,    m_data);
        chk("qcount", qcount,     mq.size());
        chk("ready",  viol_ready, mq.size() < QDEPTH);
        chk("busy",   sweep_busy, m_busy);
    endtask

    task automatic step(input bit rst, input bit v, input logic [INDEX-1:0] a,
                        input logic [WIDTH-1:0] d);
        reset      = rst;
        viol_valid = v;
        viol_addr  = a;
        viol_data  = d;
        @(posedge clk);
        model_edge(rst, v, a, d);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0);
    endtask

    initial begin
        int vprob;
        bit rst;
        bit v;
        step(1, 0, '0, '0);
        step(1, 0, '0, '0);

        // single report
        step(0, 1, 4'd5, 8'hA3);
        idle(4);

        // back-to-back stream keeps up with the drain
        for (int i = 1; i <= 6; i++) step(0, 1, i[INDEX-1:0], 8'($urandom));
        idle(3);

        // duplicates to the same address stay ordered
        step(0, 1, 4'd3, 8'h11);
        step(0, 1, 4'd3, 8'h22);
        idle(3);

`ifdef LDVIO_PERIODIC_CLEAR_EN
        // report arrives mid-sweep, then a flood fills the FIFO
        step(1, 0, '0, '0);
        idle(CP);
        idle(1);
        step(0, 1, 4'd9, 8'h7F);
        for (int i = 1; i <= 6; i++) step(0, 1, i[INDEX-1:0], 8'($urandom));
        idle(DEPTH + 2 * CP);

        // reset during sweep index 6 with two reports queued
        step(1, 0, '0, '0);
        idle(CP);
        step(0, 1, 4'd2, 8'h55);
        step(0, 1, 4'd4, 8'h66);
        idle(4);
        step(1, 0, '0, '0);
        idle(5);
`endif

        vprob = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) vprob = $urandom_range(0, 2) * 45 + 10;
            rst = ($urandom_range(0, 299) == 0);
            v   = ($urandom_range(0, 99) < vprob);
            step(rst, v, INDEX'($urandom), WIDTH'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
